// File: rtl/counter_sequencer_rr.sv
// +--------------------------------------------------------------------------+
// | counter_sequencer_rr: round-robin owner of one shared WIDTH-bit counter;  |
// | each grant runs a burst 0..limit, then pulses cout/done.                  |
// | Optional: `define COUNTER_SEQ_TICK_EN adds a tick input that gates RUN.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module counter_sequencer_rr #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESET,
`ifdef COUNTER_SEQ_TICK_EN
  input  logic                   tick,
`endif
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] limit,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [WIDTH-1:0]       O,
  output logic                   cout,
  output logic [N_REQ-1:0]       done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q,  done_d;
  logic [WIDTH-1:0]   o_q,     o_d;
  logic [WIDTH-1:0]   lim_q,   lim_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               cout_q,  cout_d;

  logic               any_req;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  int                 nxt;
  logic               tick_w;

`ifdef COUNTER_SEQ_TICK_EN
  assign tick_w = tick;
`else
  assign tick_w = 1'b1;
`endif

  // First requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    any_req  = 1'b0;
    sel      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_req && req[cand_idx]) begin
        any_req = 1'b1;
        sel     = cand_idx;
      end
    end
    nxt = int'(sel) + 1;
    if (nxt >= N_REQ) nxt = 0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    o_d     = o_q;
    lim_d   = lim_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cout_d  = 1'b0;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_RUN;
          grant_d = N_REQ'(1) << sel;
          o_d     = '0;
          lim_d   = limit[int'(sel)*WIDTH +: WIDTH];
          owner_d = sel;
          ptr_d   = IDX_W'(nxt);
        end
      end
      S_RUN: begin
        // A dropped request aborts on any cycle, tick or not.
        if (!req[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (tick_w) begin
          if (o_q == lim_q) begin
            state_d = S_DONE;
            grant_d = '0;
            cout_d  = 1'b1;
            done_d  = N_REQ'(1) << owner_q;
          end else begin
            o_d = o_q + WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      o_q     <= '0;
      lim_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      o_q     <= o_d;
      lim_q   <= lim_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cout_q  <= cout_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != S_IDLE);
  assign O     = o_q;
  assign cout  = cout_q;
  assign done  = done_q;

endmodule

`default_nettype wire
